// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared state encoding, default timeout and strobe bundle for the
//            instruction-fetch sequencer.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int DEF_MEM_TIMEOUT = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_T0     = 3'd1;
    localparam logic [2:0] S_T1     = 3'd2;
    localparam logic [2:0] S_T1W    = 3'd3;
    localparam logic [2:0] S_T2     = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    typedef struct packed {
        logic PCout;
        logic Zlowout;
        logic MDRout;
        logic MARin;
        logic IncPC;
        logic Zin;
        logic PCin;
        logic Read;
        logic MDRin;
        logic IRin;
    } strobe_t;

    // Only one bus source per state keeps the downstream priority encoder honest.
    function automatic strobe_t decode_strobes(input state_t s);
        strobe_t st;
        st = '0;
        case (s)
            S_T0: begin
                st.PCout = 1'b1;
                st.MARin = 1'b1;
                st.IncPC = 1'b1;
                st.Zin   = 1'b1;
            end
            S_T1: begin
                st.Zlowout = 1'b1;
                st.PCin    = 1'b1;
                st.Read    = 1'b1;
                st.MDRin   = 1'b1;
            end
            S_T1W: begin
                st.Read  = 1'b1;
                st.MDRin = 1'b1;
            end
            S_T2: begin
                st.MDRout = 1'b1;
                st.IRin   = 1'b1;
            end
            default: ;
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_wait_timer
// Purpose  : Loadable memory-wait cycle counter with a terminal-count flag.
// Revision : 1.0
// ============================================================================
module fetch_wait_timer #(
    parameter int TERMINAL = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_inc,
    output logic o_tc
);
    localparam int c_CNT_W = $clog2(TERMINAL) + 1;

    logic [c_CNT_W-1:0] r_count;

    // Load value is 1 because the load cycle itself is the first wait cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_CNT_W'(1);
        end else if (i_inc) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign o_tc = (r_count == c_CNT_W'(TERMINAL - 1));

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Moore FSM driving the T0-T2 fetch microsequence and the execute
//            handshake. Define FETCH_PERF_EN to add the stall_count output.
// Revision : 1.0
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               run,
    input  logic               halt_req,
    input  logic               mem_ready,
    input  logic               ex_done,
    output logic               PCout,
    output logic               Zlowout,
    output logic               MDRout,
    output logic               MARin,
    output logic               IncPC,
    output logic               Zin,
    output logic               PCin,
    output logic               Read,
    output logic               MDRin,
    output logic               IRin,
    output logic               ex_start,
    output logic               running,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    state_t              r_state;
    state_t              w_next;
    logic                r_ex_start;
    logic                r_halt_pending;
    logic [COUNT_W-1:0]  r_instr_count;
    strobe_t             w_strobes;
    logic                w_tc;
    logic                w_done_ok;
    logic                w_active;

    assign w_active  = (r_state != S_IDLE) && (r_state != S_HALTED) && (r_state != S_FAULT);
    // The EXEC entry cycle is exactly the cycle in which ex_start is high.
    assign w_done_ok = (r_state == S_EXEC) && !r_ex_start && ex_done;

    fetch_wait_timer #(
        .TERMINAL (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clock),
        .rst    (clear),
        .i_load (r_state == S_T1),
        .i_inc  ((r_state == S_T1W) && !mem_ready && !w_tc),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_T0;
            S_T0:     w_next = S_T1;
            S_T1:     w_next = mem_ready ? S_T2 : S_T1W;
            S_T1W: begin
                if (mem_ready)  w_next = S_T2;
                else if (w_tc)  w_next = S_FAULT;
            end
            S_T2:     w_next = S_EXEC;
            S_EXEC: begin
                if (w_done_ok) begin
                    w_next = (r_halt_pending || halt_req || !run) ? S_HALTED : S_T0;
                end
            end
            S_HALTED: if (!run) w_next = S_IDLE;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state        <= S_IDLE;
            r_ex_start     <= 1'b0;
            r_halt_pending <= 1'b0;
            r_instr_count  <= '0;
        end else begin
            r_state    <= w_next;
            r_ex_start <= (r_state == S_T2);
            if ((r_state == S_HALTED) && !run) begin
                r_halt_pending <= 1'b0;
            end else if (halt_req && w_active) begin
                r_halt_pending <= 1'b1;
            end
            if (w_done_ok) begin
                r_instr_count <= r_instr_count + COUNT_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_stall_count <= '0;
        end else if (((r_state == S_T1W) || ((r_state == S_EXEC) && !r_ex_start))
                     && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    assign w_strobes   = decode_strobes(r_state);
    assign PCout       = w_strobes.PCout;
    assign Zlowout     = w_strobes.Zlowout;
    assign MDRout      = w_strobes.MDRout;
    assign MARin       = w_strobes.MARin;
    assign IncPC       = w_strobes.IncPC;
    assign Zin         = w_strobes.Zin;
    assign PCin        = w_strobes.PCin;
    assign Read        = w_strobes.Read;
    assign MDRin       = w_strobes.MDRin;
    assign IRin        = w_strobes.IRin;
    assign ex_start    = r_ex_start;
    assign running     = w_active;
    assign fault       = (r_state == S_FAULT);
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire
